demux_1_32_sequencer: RTL and testbench

DEMUX_1_32_SEQUENCER -- requirements
Module: demux_1_32_sequencer

---
 rtl/demux_seq_pkg.sv | 14 +
 rtl/demux_next_channel.sv | 23 ++
 rtl/demux_1_32_sequencer.sv | 148 ++++++++++++++
 tb/tb_demux_1_32_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_seq_pkg.sv
// Shared types and constants for the 1:32 demux sequencer.
package demux_seq_pkg;

  localparam int unsigned NUM_CH = 32;
  localparam int unsigned SEL_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/demux_next_channel.sv
// Finds the lowest set mask bit strictly above idx_i, or at/above 0 when first_i is set.
module demux_next_channel
  import demux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  idx_i,
  input  logic              first_i,
  output logic [SEL_W-1:0]  ch_o,
  output logic              found_o
);

  always_comb begin
    ch_o    = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found_o && mask_i[i] && (first_i || (i > 32'(idx_i)))) begin
        found_o = 1'b1;
        ch_o    = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/demux_1_32_sequencer.sv
// Steps a 1:32 demux through the masked channels of a captured frame,
// dwelling DWELL_CYCLES per channel with a one-cycle break-before-make gap.
module demux_1_32_sequencer
  import demux_seq_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic              Clk_In,
  input  logic              Reset_In,
  input  logic [NUM_CH-1:0] Frame_In,
  input  logic [NUM_CH-1:0] Mask_In,
  input  logic              Frame_Valid_In,
  output logic              Frame_Ready_Out,
  input  logic              Abort_In,
  output logic              Enable_Out,
  output logic [SEL_W-1:0]  Select_Out,
  output logic              Data_Out,
  output logic              Busy_Out,
  output logic              Done_Out
);

  localparam int unsigned      CNT_W      = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [NUM_CH-1:0] frame_q, frame_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              data_q, data_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic              nc_first;
  logic [NUM_CH-1:0] nc_mask;
  logic [NUM_CH-1:0] frame_src;
  logic [SEL_W-1:0]  nc_ch;
  logic              nc_found;

  // In IDLE the search runs on the live inputs so the first channel is ready at accept.
  assign nc_first  = (state_q == ST_IDLE);
  assign nc_mask   = nc_first ? Mask_In  : mask_q;
  assign frame_src = nc_first ? Frame_In : frame_q;

  demux_next_channel u_next (
    .mask_i  (nc_mask),
    .idx_i   (sel_q),
    .first_i (nc_first),
    .ch_o    (nc_ch),
    .found_o (nc_found)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    sel_d   = sel_q;
    data_d  = data_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ready_d = ready_q;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (state_q == ST_GAP || (Frame_Valid_In && ready_q && !Abort_In)) begin
          if (state_q == ST_IDLE) begin
            frame_d = Frame_In;
            mask_d  = Mask_In;
          end
          busy_d  = 1'b1;
          ready_d = 1'b0;
          en_d    = 1'b0;
          if (nc_found) begin
            state_d = ST_DRIVE;
            sel_d   = nc_ch;
            data_d  = frame_src[nc_ch];
            en_d    = 1'b1;
            dwell_d = DWELL_LOAD;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        if (dwell_q == '0) begin
          state_d = ST_GAP;
          en_d    = 1'b0;
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (Abort_In && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      sel_q   <= '0;
      data_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign Frame_Ready_Out = ready_q;
  assign Enable_Out      = en_q;
  assign Select_Out      = sel_q;
  assign Data_Out        = data_q;
  assign Busy_Out        = busy_q;
  assign Done_Out        = done_q;

endmodule

// File: tb/tb_demux_1_32_sequencer.sv
// Self-checking bench: per-frame output schedule model plus directed frame scenarios.
module tb_demux_1_32_sequencer;

  localparam int unsigned DWELL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] frame = '0;
  logic [31:0] mask = '0;
  logic        valid = 1'b0;
  logic        abort = 1'b0;
  logic        Frame_Ready_Out, Enable_Out, Data_Out, Busy_Out, Done_Out;
  logic [4:0]  Select_Out;

  always #5 clk = ~clk;

  demux_1_32_sequencer #(.DWELL_CYCLES(DWELL)) dut (
    .Clk_In          (clk),
    .Reset_In        (rst),
    .Frame_In        (frame),
    .Mask_In         (mask),
    .Frame_Valid_In  (valid),
    .Frame_Ready_Out (Frame_Ready_Out),
    .Abort_In        (abort),
    .Enable_Out      (Enable_Out),
    .Select_Out      (Select_Out),
    .Data_Out        (Data_Out),
    .Busy_Out        (Busy_Out),
    .Done_Out        (Done_Out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Observable output tuple, one entry per clock cycle.
  typedef struct packed {
    logic       en;
    logic [4:0] sel;
    logic       data;
    logic       busy;
    logic       done;
    logic       ready;
  } obs_t;

  obs_t exp_o;
  obs_t sched[$];
  bit   model_ok = 0;

  function automatic obs_t mk(logic en, logic [4:0] sel, logic data, logic busy, logic done, logic ready);
    obs_t o;
    o.en = en; o.sel = sel; o.data = data; o.busy = busy; o.done = done; o.ready = ready;
    return o;
  endfunction

  // Whole-frame schedule: each set channel gives DWELL enabled cycles and one gap, then a done cycle.
  function automatic void build(logic [31:0] f, logic [31:0] m);
    logic [4:0] s = exp_o.sel;
    logic       d = exp_o.data;
    sched.delete();
    for (int k = 0; k < 32; k++) begin
      if (m[k]) begin
        s = 5'(k);
        d = f[k];
        for (int c = 0; c < int'(DWELL); c++) sched.push_back(mk(1'b1, s, d, 1'b1, 1'b0, 1'b0));
        sched.push_back(mk(1'b0, s, d, 1'b1, 1'b0, 1'b0));
      end
    end
    sched.push_back(mk(1'b0, s, d, 1'b1, 1'b1, 1'b0));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sched.delete();
      exp_o = mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      model_ok = 1;
    end else if (model_ok) begin
      if (exp_o.busy) begin
        if (abort) begin
          sched.delete();
          exp_o = mk(1'b0, exp_o.sel, exp_o.data, 1'b0, 1'b0, 1'b1);
        end else if (sched.size() > 0) begin
          exp_o = sched.pop_front();
        end else begin
          exp_o = mk(1'b0, exp_o.sel, exp_o.data, 1'b0, 1'b0, 1'b1);
        end
      end else if (valid && !abort) begin
        build(frame, mask);
        exp_o = sched.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok)
      chk("outputs", {Enable_Out, Select_Out, Data_Out, Busy_Out, Done_Out, Frame_Ready_Out}, exp_o);
  end

  int   en_cyc = 0, busy_cyc = 0, done_cnt = 0;
  int   sel_seq[$];
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (Enable_Out && !prev_en) sel_seq.push_back(int'(Select_Out));
    if (Enable_Out) en_cyc++;
    if (Busy_Out && !Done_Out) busy_cyc++;
    if (Done_Out) done_cnt++;
    prev_en = Enable_Out;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    en_cyc = 0; busy_cyc = 0; done_cnt = 0;
    sel_seq.delete();
  endtask

  task automatic send(input logic [31:0] f, input logic [31:0] m);
    step();
    frame = f; mask = m; valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && !Frame_Ready_Out; i++) step();
    chk(name, Frame_Ready_Out, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    rst = 1'b0;
    chk("reset_values", {Enable_Out, Select_Out, Data_Out, Busy_Out, Done_Out, Frame_Ready_Out}, 10'h001);

    // Single channel 0
    clr();
    send(32'h1, 32'h1);
    chk("f1_first_drive", {Enable_Out, Select_Out, Data_Out}, 7'b1_00000_1);
    wait_idle("f1_timeout");
    chk("f1_en_cycles", en_cyc, 4);
    chk("f1_busy_cycles", busy_cyc, 5);
    chk("f1_done_pulses", done_cnt, 1);
    chk("f1_channels", sel_seq.size(), 1);

    // All channels
    clr();
    send(32'hA5A5_A5A5, 32'hFFFF_FFFF);
    wait_idle("f2_timeout");
    chk("f2_busy_cycles", busy_cyc, 160);
    chk("f2_en_cycles", en_cyc, 128);
    chk("f2_done_pulses", done_cnt, 1);
    chk("f2_channels", sel_seq.size(), 32);
    for (int i = 0; i < 32; i++) chk("f2_select_order", sel_seq[i], i);

    // Channels 0 and 31 only; 31 is terminal
    clr();
    send(32'h8000_0000, 32'h8000_0001);
    wait_idle("f3_timeout");
    chk("f3_busy_cycles", busy_cyc, 10);
    chk("f3_channels", sel_seq.size(), 2);
    chk("f3_first_sel", sel_seq[0], 0);
    chk("f3_second_sel", sel_seq[1], 31);

    // Empty mask
    clr();
    send(32'hFFFF_FFFF, 32'h0);
    chk("f4_done_after_accept", {Done_Out, Enable_Out, Busy_Out}, 3'b101);
    wait_idle("f4_timeout");
    chk("f4_en_cycles", en_cyc, 0);
    chk("f4_done_pulses", done_cnt, 1);

    // Abort on the second drive cycle of channel 3
    clr();
    send(32'h0000_0008, 32'h0000_0018);
    chk("f5_on_ch3", {Enable_Out, Select_Out}, 6'b1_00011);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("f5_after_abort", {Enable_Out, Busy_Out, Frame_Ready_Out}, 3'b001);
    repeat (4) step();
    chk("f5_no_done", done_cnt, 0);

    clr();
    send(32'h0000_0010, 32'h0000_0010);
    wait_idle("f5b_timeout");
    chk("f5b_busy_cycles", busy_cyc, 5);
    chk("f5b_done_pulses", done_cnt, 1);

    // Valid held while busy, then reset during a gap
    clr();
    step();
    frame = 32'h2; mask = 32'h3; valid = 1'b1;
    step();
    frame = 32'hFFFF_FFFD; mask = 32'hFFFF_FFFF;
    for (int i = 0; i < 20 && !(Busy_Out && !Enable_Out && !Done_Out); i++) step();
    chk("f6_reached_gap", {Busy_Out, Enable_Out, Select_Out}, 7'b10_00000);
    rst = 1'b1;
    step();
    rst = 1'b0; valid = 1'b0;
    chk("f6_reset_values", {Enable_Out, Select_Out, Data_Out, Busy_Out, Done_Out, Frame_Ready_Out}, 10'h001);
    repeat (4) step();
    chk("f6_no_done", done_cnt, 0);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
